// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use and MDU scoreboard hazard unit
// for the 5-stage RISC-V pipeline, with a stall-cycle counter.
module fwd_hazard_unit #(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_Rwen,
    input  logic              id_valid,
    input  logic              id_is_mdu,
    input  logic              flush,
    input  logic [REG_AW-1:0] id_ex_rs1,
    input  logic [REG_AW-1:0] id_ex_rs2,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_Rwen,
    input  logic              id_ex_is_load,
    input  logic              ex_mem_Rwen,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              mem_wb_Rwen,
    input  logic [REG_AW-1:0] mem_wb_rd,
    output logic [1:0]        FwdA_sel,
    output logic [1:0]        FwdB_sel,
    output logic              stall,
    output logic              mdu_issue,
    output logic              mdu_busy,
    output logic              mdu_done,
    output logic [REG_AW-1:0] mdu_rd,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(MDU_LAT - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [REG_AW-1:0] mdu_rd_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    logic ex_hit_a, wb_hit_a;
    logic ex_hit_b, wb_hit_b;
    logic rs1_q_rd, rs2_q_rd;
    logic load_use, mdu_raw, mdu_waw, mdu_struct;

    assign ex_hit_a = ex_mem_Rwen && (ex_mem_rd != '0)
                   && (id_ex_rs1 == ex_mem_rd);
    assign wb_hit_a = mem_wb_Rwen && (mem_wb_rd != '0)
                   && (id_ex_rs1 == mem_wb_rd);
    assign ex_hit_b = ex_mem_Rwen && (ex_mem_rd != '0)
                   && (id_ex_rs2 == ex_mem_rd);
    assign wb_hit_b = mem_wb_Rwen && (mem_wb_rd != '0)
                   && (id_ex_rs2 == mem_wb_rd);

    always_comb begin
        FwdA_sel = 2'b00;
        if (ex_hit_a)      FwdA_sel = 2'b01;
        else if (wb_hit_a) FwdA_sel = 2'b10;
    end

    always_comb begin
        FwdB_sel = 2'b00;
        if (ex_hit_b)      FwdB_sel = 2'b01;
        else if (wb_hit_b) FwdB_sel = 2'b10;
    end

    assign rs1_q_rd = id_valid && id_rs1_used && (id_rs1 != '0);
    assign rs2_q_rd = id_valid && id_rs2_used && (id_rs2 != '0);

    assign load_use = id_ex_is_load && id_ex_Rwen && (id_ex_rd != '0)
                   && ((rs1_q_rd && (id_rs1 == id_ex_rd))
                    || (rs2_q_rd && (id_rs2 == id_ex_rd)));

    assign mdu_busy = (state_q == BUSY);
    assign mdu_done = mdu_busy && (cnt_q == '0);
    assign mdu_rd   = mdu_rd_q;

    // Busy covers the done cycle, so dependents read the written RF after it.
    assign mdu_raw = mdu_busy
                  && ((rs1_q_rd && (id_rs1 == mdu_rd_q))
                   || (rs2_q_rd && (id_rs2 == mdu_rd_q)));
    assign mdu_waw = mdu_busy && id_valid && id_Rwen
                  && (id_rd != '0) && (id_rd == mdu_rd_q);
    assign mdu_struct = mdu_busy && id_valid && id_is_mdu;

    assign stall     = load_use || mdu_raw || mdu_waw || mdu_struct;
    assign mdu_issue = id_valid && id_is_mdu && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mdu_rd_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mdu_issue) begin
                        state_q  <= BUSY;
                        cnt_q    <= LAT_M1;
                        mdu_rd_q <= id_rd;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) cnt_q   <= cnt_q - 1'b1;
                    else             state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit against a cycle-level
// behavioural model of forwarding, stalls and the MDU scoreboard.
module tb_fwd_hazard_unit;

    localparam int AW   = 5;
    localparam int LAT  = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic id_rs1_used, id_rs2_used, id_Rwen, id_valid, id_is_mdu, flush;
    logic [AW-1:0] id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic id_ex_Rwen, id_ex_is_load, ex_mem_Rwen, mem_wb_Rwen;
    logic [1:0] FwdA_sel, FwdB_sel;
    logic stall, mdu_issue, mdu_busy, mdu_done;
    logic [AW-1:0] mdu_rd;
    logic [CW-1:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    int m_cycle = 0;
    bit m_active = 0;
    int m_done_cycle = 0;
    logic [AW-1:0] m_rd = '0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(AW), .MDU_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_Rwen(id_Rwen), .id_valid(id_valid),
        .id_is_mdu(id_is_mdu), .flush(flush),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_Rwen(id_ex_Rwen),
        .id_ex_is_load(id_ex_is_load),
        .ex_mem_Rwen(ex_mem_Rwen), .ex_mem_rd(ex_mem_rd),
        .mem_wb_Rwen(mem_wb_Rwen), .mem_wb_rd(mem_wb_rd),
        .FwdA_sel(FwdA_sel), .FwdB_sel(FwdB_sel), .stall(stall),
        .mdu_issue(mdu_issue), .mdu_busy(mdu_busy),
        .mdu_done(mdu_done), .mdu_rd(mdu_rd), .stall_cnt(stall_cnt)
    );

    function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
        if (ex_mem_Rwen && ex_mem_rd != 0 && rs == ex_mem_rd) return 2'b01;
        if (mem_wb_Rwen && mem_wb_rd != 0 && rs == mem_wb_rd) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit m_reads(input logic [AW-1:0] r);
        bit a, b;
        a = id_valid && id_rs1_used && id_rs1 != 0 && id_rs1 == r;
        b = id_valid && id_rs2_used && id_rs2 != 0 && id_rs2 == r;
        return a || b;
    endfunction

    function automatic bit m_stall();
        bit lu, md;
        lu = id_ex_is_load && id_ex_Rwen && id_ex_rd != 0 && m_reads(id_ex_rd);
        md = id_valid && m_active &&
             (m_reads(m_rd) || id_is_mdu ||
              (id_Rwen && id_rd != 0 && id_rd == m_rd));
        return lu || md;
    endfunction

    function automatic bit m_issue();
        return id_valid && id_is_mdu && !m_stall() && !flush;
    endfunction

    function automatic bit m_done();
        return m_active && (m_cycle == m_done_cycle);
    endfunction

    task automatic idle_inputs();
        {id_rs1, id_rs2, id_rd, id_ex_rs1, id_ex_rs2} = '0;
        {id_ex_rd, ex_mem_rd, mem_wb_rd} = '0;
        {id_rs1_used, id_rs2_used, id_Rwen, id_valid, id_is_mdu} = '0;
        {flush, id_ex_Rwen, id_ex_is_load, ex_mem_Rwen, mem_wb_Rwen} = '0;
    endtask

    task automatic tick();
        bit s, iss, dn;
        s = m_stall();
        iss = m_issue();
        dn = m_done();
        @(posedge clk);
        m_cycle++;
        if (s && m_cnt < CMAX) m_cnt++;
        if (dn) m_active = 0;
        if (iss) begin
            m_active = 1;
            m_done_cycle = m_cycle + LAT - 1;
            m_rd = id_rd;
        end
        #1;
    endtask

    task automatic model_reset();
        m_active = 0;
        m_rd = '0;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #4;
        tests++;
        if ({mdu_busy, mdu_done, mdu_issue, stall} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags got %b want 0000",
                     {mdu_busy, mdu_done, mdu_issue, stall});
        end
        tests++;
        if (stall_cnt !== '0 || mdu_rd !== '0) begin
            fails++;
            $display("FAIL reset_regs cnt %0d rd %0d want 0 0", stall_cnt, mdu_rd);
        end
        tests++;
        if ({FwdA_sel, FwdB_sel} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_fwd got %b want 0000", {FwdA_sel, FwdB_sel});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_forward();
        logic [1:0] want [3];
        want[0] = 2'b01;
        want[1] = 2'b10;
        want[2] = 2'b00;
        idle_inputs();
        for (int p = 0; p < 3; p++) begin
            ex_mem_Rwen = (p != 1);
            mem_wb_Rwen = 1'b1;
            ex_mem_rd = (p == 2) ? 5'd0 : 5'd5;
            mem_wb_rd = (p == 2) ? 5'd0 : 5'd5;
            id_ex_rs1 = 5'd5;
            id_ex_rs2 = 5'd5;
            #1;
            tests++;
            if (FwdA_sel !== want[p]) begin
                fails++;
                $display("FAIL fwdA_p%0d got %b want %b", p, FwdA_sel, want[p]);
            end
            tests++;
            if (FwdB_sel !== want[p]) begin
                fails++;
                $display("FAIL fwdB_p%0d got %b want %b", p, FwdB_sel, want[p]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        id_ex_is_load = 1'b1;
        id_ex_Rwen = 1'b1;
        id_ex_rd = 5'd7;
        id_valid = 1'b1;
        id_rs2 = 5'd7;
        id_rs2_used = 1'b1;
        #4;
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL loaduse_stall got %b want 1", stall);
        end
        tick();
        id_ex_is_load = 1'b0;
        id_ex_Rwen = 1'b0;
        id_ex_rd = '0;
        #4;
        tests++;
        if (stall !== 1'b0 || stall_cnt !== 4'd1) begin
            fails++;
            $display("FAIL loaduse_release stall %b cnt %0d want 0 1",
                     stall, stall_cnt);
        end
        id_ex_is_load = 1'b1;
        id_ex_Rwen = 1'b1;
        id_ex_rd = 5'd7;
        id_rs2_used = 1'b0;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL loaduse_unused got %b want 0", stall);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_mdu();
        idle_inputs();
        id_valid = 1'b1;
        id_is_mdu = 1'b1;
        id_Rwen = 1'b1;
        id_rd = 5'd9;
        #4;
        tests++;
        if (mdu_issue !== 1'b1) begin
            fails++;
            $display("FAIL mdu_issue got %b want 1", mdu_issue);
        end
        tick();
        for (int c = 0; c <= 4; c++) begin
            idle_inputs();
            id_valid = 1'b1;
            case (c)
                1: begin id_is_mdu = 1'b1; id_Rwen = 1'b1; id_rd = 5'd11; end
                2: begin id_Rwen = 1'b1; id_rd = 5'd9; end
                default: begin id_rs1 = 5'd9; id_rs1_used = 1'b1; end
            endcase
            #4;
            tests++;
            if (mdu_busy !== (c <= 3) || mdu_done !== (c == 3)) begin
                fails++;
                $display("FAIL mdu_c%0d busy %b done %b want %b %b",
                         c, mdu_busy, mdu_done, c <= 3, c == 3);
            end
            tests++;
            if (stall !== (c <= 3) || mdu_issue !== 1'b0) begin
                fails++;
                $display("FAIL mdu_stall_c%0d stall %b issue %b want %b 0",
                         c, stall, mdu_issue, c <= 3);
            end
            tests++;
            if (stall_cnt !== 4'(m_cnt)) begin
                fails++;
                $display("FAIL mdu_cnt_c%0d got %0d want %0d", c, stall_cnt, m_cnt);
            end
            tick();
        end
        idle_inputs();
        id_valid = 1'b1;
        id_is_mdu = 1'b1;
        id_Rwen = 1'b1;
        id_rd = 5'd9;
        #1;
        tick();
        idle_inputs();
        id_valid = 1'b1;
        id_Rwen = 1'b1;
        id_rd = 5'd10;
        id_rs1 = 5'd9;
        #4;
        tests++;
        if (stall !== 1'b0 || mdu_busy !== 1'b1 || mdu_rd !== 5'd9) begin
            fails++;
            $display("FAIL mdu_x10 stall %b busy %b rd %0d want 0 1 9",
                     stall, mdu_busy, mdu_rd);
        end
        idle_inputs();
        for (int i = 0; i < LAT; i++) tick();
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        idle_inputs();
        id_valid = 1'b1;
        id_is_mdu = 1'b1;
        id_rd = 5'd12;
        #1;
        tick();
        idle_inputs();
        id_valid = 1'b1;
        id_is_mdu = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if (mdu_busy !== 1'b0 || stall_cnt !== '0 || mdu_done !== 1'b0) begin
            fails++;
            $display("FAIL midreset busy %b cnt %0d done %b want 0 0 0",
                     mdu_busy, stall_cnt, mdu_done);
        end
        idle_inputs();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            #4;
            if (mdu_done === 1'b1) seen = 1;
            tick();
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL midreset_done got 1 want 0");
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        id_valid = 1'b1;
        id_is_mdu = 1'b1;
        id_rd = 5'd3;
        flush = 1'b1;
        #4;
        tests++;
        if (mdu_issue !== 1'b0) begin
            fails++;
            $display("FAIL flush_issue got %b want 0", mdu_issue);
        end
        tick();
        idle_inputs();
        #1;
        tests++;
        if (mdu_busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_busy got %b want 0", mdu_busy);
        end
    endtask

    task automatic test_saturate();
        test_reset();
        id_ex_is_load = 1'b1;
        id_ex_Rwen = 1'b1;
        id_ex_rd = 5'd4;
        id_valid = 1'b1;
        id_rs1 = 5'd4;
        id_rs1_used = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        tests++;
        if (stall_cnt !== 4'd15) begin
            fails++;
            $display("FAIL saturate got %0d want 15", stall_cnt);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            id_rs1 = AW'($urandom_range(0, 3));
            id_rs2 = AW'($urandom_range(0, 3));
            id_rd = AW'($urandom_range(0, 3));
            id_ex_rs1 = AW'($urandom_range(0, 3));
            id_ex_rs2 = AW'($urandom_range(0, 3));
            id_ex_rd = AW'($urandom_range(0, 3));
            ex_mem_rd = AW'($urandom_range(0, 3));
            mem_wb_rd = AW'($urandom_range(0, 3));
            {id_rs1_used, id_rs2_used, id_Rwen, id_valid} = 4'($urandom);
            id_is_mdu = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            {id_ex_Rwen, id_ex_is_load, ex_mem_Rwen, mem_wb_Rwen} = 4'($urandom);
            #4;
            tests++;
            if (FwdA_sel !== m_fwd(id_ex_rs1) || FwdB_sel !== m_fwd(id_ex_rs2)
                || stall !== m_stall() || mdu_issue !== m_issue()
                || mdu_busy !== m_active || mdu_done !== m_done()
                || mdu_rd !== m_rd || stall_cnt !== 4'(m_cnt)) begin
                fails++;
                if (bad < 10)
                    $display("FAIL rand_%0d fa %b fb %b st %b is %b bz %b dn %b rd %0d cnt %0d want %b %b %b %b %b %b %0d %0d",
                             i, FwdA_sel, FwdB_sel, stall, mdu_issue, mdu_busy,
                             mdu_done, mdu_rd, stall_cnt, m_fwd(id_ex_rs1),
                             m_fwd(id_ex_rs2), m_stall(), m_issue(), m_active,
                             m_done(), m_rd, m_cnt);
                bad++;
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_forward();
        test_load_use();
        test_mdu();
        test_reset_mid_op();
        test_flush();
        test_saturate();
        test_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
